// File: rtl/pipelined_csel_addsub.sv
// Pipelined carry-select adder/subtractor: one BLOCK-bit slice resolved per stage,
// with a global stall enable driven by the output handshake.
module pipelined_csel_addsub #(
    parameter int WIDTH = 16,
    parameter int BLOCK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int NBLK = WIDTH / BLOCK;

    generate
        if (BLOCK < 1 || (WIDTH % BLOCK) != 0 || WIDTH < 2 * BLOCK) begin : g_param_check
            $error("pipelined_csel_addsub: WIDTH=%0d must be a multiple of BLOCK=%0d and at least 2*BLOCK",
                   WIDTH, BLOCK);
        end
    endgenerate

    // Stage k holds operands still to be resolved plus sum bits [k*BLOCK+BLOCK-1:0].
    logic [NBLK-1:0][WIDTH-1:0] a_q, a_d;
    logic [NBLK-1:0][WIDTH-1:0] b_q, b_d;
    logic [NBLK-1:0][WIDTH-1:0] s_q, s_d;
    logic [NBLK-1:0]            c_q, c_d;
    logic [NBLK-1:0]            v_q, v_d;
    logic                       ovf_q, ovf_d;
    logic                       zero_q, zero_d;

    logic [NBLK-1:1][BLOCK:0]   cand0;
    logic [NBLK-1:1][BLOCK:0]   cand1;
    logic [WIDTH-1:0]           b_eff;
    logic [BLOCK:0]             blk0;
    logic                       c0;
    logic                       en;

    // Both carry-in candidates for every block past the first.
    genvar gi;
    generate
        for (gi = 1; gi < NBLK; gi++) begin : g_cand
            assign cand0[gi] = {1'b0, a_q[gi-1][gi*BLOCK +: BLOCK]}
                             + {1'b0, b_q[gi-1][gi*BLOCK +: BLOCK]};
            assign cand1[gi] = {1'b0, a_q[gi-1][gi*BLOCK +: BLOCK]}
                             + {1'b0, b_q[gi-1][gi*BLOCK +: BLOCK]}
                             + {{BLOCK{1'b0}}, 1'b1};
        end
    endgenerate

    always_comb begin
        en     = ~(v_q[NBLK-1] & ~out_ready);
        b_eff  = sub ? ~b : b;
        c0     = sub | cin;
        blk0   = {1'b0, a[BLOCK-1:0]} + {1'b0, b_eff[BLOCK-1:0]} + {{BLOCK{1'b0}}, c0};

        a_d    = '0;
        b_d    = '0;
        s_d    = '0;
        c_d    = '0;
        v_d    = '0;

        a_d[0]            = a;
        b_d[0]            = b_eff;
        s_d[0][BLOCK-1:0] = blk0[BLOCK-1:0];
        c_d[0]            = blk0[BLOCK];
        v_d[0]            = in_valid;

        for (int k = 1; k < NBLK; k++) begin
            a_d[k] = a_q[k-1];
            b_d[k] = b_q[k-1];
            s_d[k] = s_q[k-1];
            v_d[k] = v_q[k-1];
            s_d[k][k*BLOCK +: BLOCK] = c_q[k-1] ? cand1[k][BLOCK-1:0] : cand0[k][BLOCK-1:0];
            c_d[k]                   = c_q[k-1] ? cand1[k][BLOCK]     : cand0[k][BLOCK];
        end

        // Sign bits of A and the conditioned B ride along in the operand registers.
        ovf_d  = (a_q[NBLK-2][WIDTH-1] == b_q[NBLK-2][WIDTH-1])
               & (s_d[NBLK-1][WIDTH-1] != a_q[NBLK-2][WIDTH-1]);
        zero_d = ~|s_d[NBLK-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q    <= '0;
            b_q    <= '0;
            s_q    <= '0;
            c_q    <= '0;
            v_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (en) begin
            a_q    <= a_d;
            b_q    <= b_d;
            s_q    <= s_d;
            c_q    <= c_d;
            v_q    <= v_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign in_ready  = en;
    assign out_valid = v_q[NBLK-1];
    assign sum       = s_q[NBLK-1];
    assign cout      = c_q[NBLK-1];
    assign ovf       = ovf_q;
    assign zero      = zero_q;

    // Operand bits already consumed and sum bits not yet resolved are never read;
    // folding them here keeps lint quiet and synthesis prunes the flops.
    logic unused_skew;
    assign unused_skew = ^{a_q, b_q, s_q};

endmodule
